// File: rtl/pong_frame_renderer_if.sv
// Pixel/score bus between the VGA controller side and the pong frame renderer.
// The renderer uses the slave modport; whoever drives the scan addresses and
// paddle positions uses the master modport.
`timescale 1ns/1ps
interface pong_frame_renderer_if;
  logic [9:0]  xAddr;
  logic [9:0]  yAddr;
  logic        inDisplay;
  logic [9:0]  paddle_l_y;
  logic [9:0]  paddle_r_y;
  logic [23:0] vga_RGB;
  logic [3:0]  score_l;
  logic [3:0]  score_r;
  logic        point_pulse;
  logic        frame_tick;

  modport master (
    output xAddr, yAddr, inDisplay, paddle_l_y, paddle_r_y,
    input  vga_RGB, score_l, score_r, point_pulse, frame_tick
  );

  modport slave (
    input  xAddr, yAddr, inDisplay, paddle_l_y, paddle_r_y,
    output vga_RGB, score_l, score_r, point_pulse, frame_tick
  );
endinterface

// File: rtl/pong_frame_renderer.sv
// Pong frame renderer: draws two paddles and a ball on a black field and runs
// the game (ball motion, bounces, misses, scoring) once per frame at the end of
// active video. Optional dashed centre net: define PONG_CENTRE_NET_EN.
//
// state  | meaning
// SERVE  | ball held at centre, serve counter running (frozen once a score hits 9)
// MOVE   | ball moving, bounce/miss evaluated every frame
// SCORED | one frame after a miss: ball already recentred, then back to SERVE
`timescale 1ns/1ps
module pong_frame_renderer #(
  parameter int          BALL_SIZE    = 8,
  parameter int          BALL_SPEED   = 2,
  parameter int          PADDLE_W     = 8,
  parameter int          PADDLE_H     = 64,
  parameter int          PADDLE_L_X   = 16,
  parameter int          PADDLE_R_X   = 616,
  parameter int          SERVE_FRAMES = 60,
  parameter logic [23:0] FG_RGB       = 24'hFFFFFF
) (
  input  logic                  clock,
  input  logic                  resetn,
  pong_frame_renderer_if.slave  bus
);

  // All geometry is 11 bits so x+BALL_SIZE and similar sums never wrap.
  localparam logic [10:0] SZ     = 11'(BALL_SIZE);
  localparam logic [10:0] SPD    = 11'(BALL_SPEED);
  localparam logic [10:0] PW     = 11'(PADDLE_W);
  localparam logic [10:0] PH     = 11'(PADDLE_H);
  localparam logic [10:0] LX     = 11'(PADDLE_L_X);
  localparam logic [10:0] RX     = 11'(PADDLE_R_X);
  localparam logic [10:0] CX     = 11'(320 - BALL_SIZE / 2);
  localparam logic [10:0] CY     = 11'(240 - BALL_SIZE / 2);
  localparam logic [10:0] XMAX   = 11'd640;
  localparam logic [10:0] YMAX   = 11'd480;
  localparam logic [9:0]  PAD_MAX   = 10'(480 - PADDLE_H);
  localparam logic [9:0]  PAD_RESET = 10'd208;
  localparam int          CNT_W     = $clog2(SERVE_FRAMES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [3:0]  SCORE_MAX = 4'd9;

  typedef enum logic [1:0] {SERVE, MOVE, SCORED} state_t;

  state_t            state_q, state_d;
  logic [10:0]       ball_x, ball_y, bx_d, by_d;
  logic              dir_r, dir_d, dr_d, dd_d;
  logic [CNT_W-1:0]  serve_cnt, cnt_d;
  logic [3:0]        score_l_q, score_r_q, sl_d, sr_d;
  logic              pulse_q, pulse_d;
  logic [9:0]        pad_l_q, pad_r_q;
  logic              last_px, frame_tick_q;
  logic [23:0]       rgb_q;

  logic [10:0]       step_x, step_y;
  logic              step_dd, ovl_l, ovl_r, hit_l, hit_r, miss_l, miss_r;
  logic              game_over;

  assign game_over = (score_l_q == SCORE_MAX) || (score_r_q == SCORE_MAX);

  // End-of-frame detect: last active pixel seen, then active video drops.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      last_px      <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      last_px      <= bus.inDisplay && (bus.xAddr == 10'd639) && (bus.yAddr == 10'd479);
      frame_tick_q <= last_px && !bus.inDisplay;
    end
  end

  // One frame of ball motion: walls judged on the old position, paddles on the moved one.
  always_comb begin
    step_x  = dir_r ? ball_x + SPD : ball_x - SPD;
    step_y  = dir_d ? ball_y + SPD : ball_y - SPD;
    step_dd = dir_d;
    if (!dir_d && (ball_y < SPD)) begin
      step_y  = '0;
      step_dd = 1'b1;
    end
    if (dir_d && (ball_y + SZ + SPD > YMAX)) begin
      step_y  = YMAX - SZ;
      step_dd = 1'b0;
    end
    ovl_l  = (step_y < {1'b0, pad_l_q} + PH) && (step_y + SZ > {1'b0, pad_l_q});
    ovl_r  = (step_y < {1'b0, pad_r_q} + PH) && (step_y + SZ > {1'b0, pad_r_q});
    hit_l  = !dir_r && (step_x <= LX + PW) && (step_x + SZ > LX) && ovl_l;
    hit_r  = dir_r && (step_x + SZ >= RX) && (step_x < RX + PW) && ovl_r;
    miss_l = !dir_r && !hit_l && (ball_x < SPD);
    miss_r = dir_r && !hit_r && (ball_x + SZ + SPD > XMAX);
  end

  // Game FSM next state; only advances on frame_tick.
  always_comb begin
    state_d = state_q;
    bx_d    = ball_x;
    by_d    = ball_y;
    dr_d    = dir_r;
    dd_d    = dir_d;
    cnt_d   = serve_cnt;
    sl_d    = score_l_q;
    sr_d    = score_r_q;
    pulse_d = 1'b0;
    if (frame_tick_q) begin
      case (state_q)
        SERVE: begin
          bx_d = CX;
          by_d = CY;
          if (!game_over) begin
            if (serve_cnt == CNT_LAST) begin
              state_d = MOVE;
              cnt_d   = '0;
            end else begin
              cnt_d = serve_cnt + CNT_W'(1);
            end
          end
        end
        MOVE: begin
          bx_d = step_x;
          by_d = step_y;
          dd_d = step_dd;
          if (hit_l) begin
            bx_d = LX + PW;
            dr_d = 1'b1;
          end else if (hit_r) begin
            bx_d = RX - SZ;
            dr_d = 1'b0;
          end else if (miss_l || miss_r) begin
            // Recentre now and serve toward whoever conceded.
            bx_d    = CX;
            by_d    = CY;
            dr_d    = miss_r;
            state_d = SCORED;
            pulse_d = 1'b1;
            if (miss_l) sr_d = (score_r_q >= SCORE_MAX) ? SCORE_MAX : score_r_q + 4'd1;
            else        sl_d = (score_l_q >= SCORE_MAX) ? SCORE_MAX : score_l_q + 4'd1;
          end
        end
        SCORED: begin
          state_d = SERVE;
          cnt_d   = '0;
        end
        default: state_d = SERVE;
      endcase
    end
  end

  // Game state registers; paddles are latched once per frame to avoid tearing.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= SERVE;
      ball_x    <= CX;
      ball_y    <= CY;
      dir_r     <= 1'b1;
      dir_d     <= 1'b1;
      serve_cnt <= '0;
      score_l_q <= '0;
      score_r_q <= '0;
      pulse_q   <= 1'b0;
      pad_l_q   <= PAD_RESET;
      pad_r_q   <= PAD_RESET;
    end else begin
      state_q   <= state_d;
      ball_x    <= bx_d;
      ball_y    <= by_d;
      dir_r     <= dr_d;
      dir_d     <= dd_d;
      serve_cnt <= cnt_d;
      score_l_q <= sl_d;
      score_r_q <= sr_d;
      pulse_q   <= pulse_d;
      if (frame_tick_q) begin
        pad_l_q <= (bus.paddle_l_y > PAD_MAX) ? PAD_MAX : bus.paddle_l_y;
        pad_r_q <= (bus.paddle_r_y > PAD_MAX) ? PAD_MAX : bus.paddle_r_y;
      end
    end
  end

  logic [10:0] px, py;
  logic        in_ball, in_pl, in_pr, in_net;

  // Object hit-test for the current scan address (half-open rectangles).
  always_comb begin
    px      = {1'b0, bus.xAddr};
    py      = {1'b0, bus.yAddr};
    in_ball = (px >= ball_x) && (px < ball_x + SZ) && (py >= ball_y) && (py < ball_y + SZ);
    in_pl   = (px >= LX) && (px < LX + PW) &&
              (py >= {1'b0, pad_l_q}) && (py < {1'b0, pad_l_q} + PH);
    in_pr   = (px >= RX) && (px < RX + PW) &&
              (py >= {1'b0, pad_r_q}) && (py < {1'b0, pad_r_q} + PH);
`ifdef PONG_CENTRE_NET_EN
    in_net  = (bus.xAddr >= 10'd318) && (bus.xAddr <= 10'd321) && !bus.yAddr[4];
`else
    in_net  = 1'b0;
`endif
  end

  // Registered pixel colour, one cycle behind the scan address.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) rgb_q <= '0;
    else         rgb_q <= (bus.inDisplay && (in_ball || in_pl || in_pr || in_net)) ? FG_RGB : 24'h000000;
  end

  assign bus.vga_RGB     = rgb_q;
  assign bus.score_l     = score_l_q;
  assign bus.score_r     = score_r_q;
  assign bus.point_pulse = pulse_q;
  assign bus.frame_tick  = frame_tick_q;

endmodule

// File: tb/tb_pong_frame_renderer.sv
// Testbench for pong_frame_renderer: constant pixel table after reset, a
// mid-frame reset sequence, then many short synthetic frames checked against
// an integer game model (tracking paddles, random paddles, then paddles that
// dodge the ball until a score reaches 9, followed by game-over frames).
`timescale 1ns/1ps
module tb_pong_frame_renderer;
  logic clock  = 1'b0;
  logic resetn = 1'b0;

  pong_frame_renderer_if bus();

  pong_frame_renderer dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clock = ~clock;

`ifdef PONG_CENTRE_NET_EN
  localparam bit NET = 1'b1;
`else
  localparam bit NET = 1'b0;
`endif
  localparam int FG    = 32'h00FFFFFF;
  localparam int NETFG = NET ? FG : 0;

  int n_cmp = 0;
  int n_bad = 0;

  // Game model: integer positions, direction as +1/-1, mode 0 serve / 1 move / 2 scored.
  int m_x, m_y, m_dx, m_dy, m_sl, m_sr, m_cnt, m_mode, m_pl, m_pr;
  bit m_pulse;

  typedef struct {
    int x;
    int y;
    bit de;
    int exp;
  } vec_t;
  vec_t vt[18];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic int model_pixel(input int x, input int y, input bit de);
    if (!de) return 0;
    if (x >= m_x && x < m_x + 8 && y >= m_y && y < m_y + 8) return FG;
    if (x >= 16 && x < 24 && y >= m_pl && y < m_pl + 64) return FG;
    if (x >= 616 && x < 624 && y >= m_pr && y < m_pr + 64) return FG;
    if (NET && x >= 318 && x <= 321 && (y % 32) < 16) return FG;
    return 0;
  endfunction

  task automatic model_reset();
    m_x = 316; m_y = 236; m_dx = 1; m_dy = 1;
    m_sl = 0; m_sr = 0; m_cnt = 0; m_mode = 0;
    m_pl = 208; m_pr = 208; m_pulse = 0;
  endtask

  task automatic model_tick(input int pl_in, input int pr_in);
    int nx, ny, ndx, ndy;
    bit miss_left, miss_right;
    m_pulse = 0;
    if (m_mode == 0) begin
      if (!(m_sl == 9 || m_sr == 9)) begin
        if (m_cnt == 59) begin m_mode = 1; m_cnt = 0; end
        else m_cnt++;
      end
    end else if (m_mode == 2) begin
      m_mode = 0; m_cnt = 0;
    end else begin
      nx = m_x + 2 * m_dx; ny = m_y + 2 * m_dy; ndx = m_dx; ndy = m_dy;
      miss_left = 0; miss_right = 0;
      if (m_dy < 0 && m_y < 2)        begin ny = 0;   ndy = 1;  end
      if (m_dy > 0 && m_y + 10 > 480) begin ny = 472; ndy = -1; end
      if (m_dx < 0) begin
        if (nx <= 24 && nx + 8 > 16 && ny < m_pl + 64 && ny + 8 > m_pl) begin nx = 24; ndx = 1; end
        else if (m_x < 2) miss_left = 1;
      end else begin
        if (nx + 8 >= 616 && nx < 624 && ny < m_pr + 64 && ny + 8 > m_pr) begin nx = 608; ndx = -1; end
        else if (m_x + 10 > 640) miss_right = 1;
      end
      if (miss_left || miss_right) begin
        if (miss_left) m_sr = (m_sr < 9) ? m_sr + 1 : 9;
        else           m_sl = (m_sl < 9) ? m_sl + 1 : 9;
        m_x = 316; m_y = 236; m_dy = ndy;
        m_dx = miss_left ? -1 : 1;
        m_mode = 2; m_pulse = 1;
      end else begin
        m_x = nx; m_y = ny; m_dx = ndx; m_dy = ndy;
      end
    end
    m_pl = (pl_in > 416) ? 416 : pl_in;
    m_pr = (pr_in > 416) ? 416 : pr_in;
  endtask

  task automatic drive_px(input int x, input int y, input bit de);
    bus.xAddr     = 10'(x);
    bus.yAddr     = 10'(y);
    bus.inDisplay = de;
  endtask

  // One compressed frame: a few scanned pixels, the last active pixel, blanking.
  task automatic run_frame(input int pl, input int pr, input int npix);
    int x, y;
    bus.paddle_l_y = 10'(pl);
    bus.paddle_r_y = 10'(pr);
    for (int i = 0; i < npix; i++) begin
      if (i % 2 == 0) begin
        x = clampi(m_x + int'($urandom_range(0, 11)) - 2, 0, 638);
        y = clampi(m_y + int'($urandom_range(0, 11)) - 2, 0, 479);
      end else begin
        x = int'($urandom_range(0, 638));
        y = int'($urandom_range(0, 479));
      end
      drive_px(x, y, 1'b1);
      step();
      check("pixel", int'(bus.vga_RGB), model_pixel(x, y, 1'b1));
    end
    drive_px(639, 479, 1'b1);
    step();
    drive_px(0, 0, 1'b0);
    check("tick_early", int'(bus.frame_tick), 0);
    step();
    check("tick", int'(bus.frame_tick), 1);
    step();
    model_tick(pl, pr);
    check("tick_width", int'(bus.frame_tick), 0);
    check("point_pulse", int'(bus.point_pulse), int'(m_pulse));
    check("score_l", int'(bus.score_l), m_sl);
    check("score_r", int'(bus.score_r), m_sr);
    check("ball_x", int'(dut.ball_x), m_x);
    check("ball_y", int'(dut.ball_y), m_y);
    step();
    if (m_pulse) check("pulse_width", int'(bus.point_pulse), 0);
  endtask

  initial begin
    #10ms;
    $display("FAIL timeout: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "timeout");
  end

  initial begin
    int pl, pr;
    vt[0]  = '{320, 240, 1'b1, FG};
    vt[1]  = '{100, 240, 1'b1, 0};
    vt[2]  = '{316, 236, 1'b1, FG};
    vt[3]  = '{323, 243, 1'b1, FG};
    vt[4]  = '{324, 243, 1'b1, 0};
    vt[5]  = '{316, 244, 1'b1, 0};
    vt[6]  = '{16,  208, 1'b1, FG};
    vt[7]  = '{23,  271, 1'b1, FG};
    vt[8]  = '{24,  240, 1'b1, 0};
    vt[9]  = '{20,  272, 1'b1, 0};
    vt[10] = '{616, 208, 1'b1, FG};
    vt[11] = '{624, 208, 1'b1, 0};
    vt[12] = '{320, 240, 1'b0, 0};
    vt[13] = '{319, 5,   1'b1, NETFG};
    vt[14] = '{319, 16,  1'b1, 0};
    vt[15] = '{321, 15,  1'b1, NETFG};
    vt[16] = '{322, 5,   1'b1, 0};
    vt[17] = '{318, 31,  1'b1, 0};

    drive_px(0, 0, 1'b0);
    bus.paddle_l_y = 10'd208;
    bus.paddle_r_y = 10'd208;
    model_reset();
    repeat (3) step();
    resetn = 1'b1;
    step();
    check("rst_rgb", int'(bus.vga_RGB), 0);
    check("rst_score_l", int'(bus.score_l), 0);
    check("rst_score_r", int'(bus.score_r), 0);
    check("rst_tick", int'(bus.frame_tick), 0);
    check("rst_pulse", int'(bus.point_pulse), 0);
    check("rst_ball_x", int'(dut.ball_x), 316);
    check("rst_ball_y", int'(dut.ball_y), 236);

    foreach (vt[i]) begin
      drive_px(vt[i].x, vt[i].y, vt[i].de);
      step();
      check($sformatf("vec%0d", i), int'(bus.vga_RGB), vt[i].exp);
    end

    // Reset lands between the last active pixel and the blanking edge.
    drive_px(639, 479, 1'b1);
    step();
    resetn = 1'b0;
    #1;
    drive_px(0, 0, 1'b0);
    step();
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("midrst_no_tick", int'(bus.frame_tick), 0);
    end
    check("midrst_rgb", int'(bus.vga_RGB), 0);
    check("midrst_ball_x", int'(dut.ball_x), 316);
    check("midrst_score_l", int'(bus.score_l), 0);
    model_reset();

    // Paddles follow the ball: exercises paddle and wall bounces.
    for (int f = 0; f < 400; f++) begin
      pl = clampi(m_y - 28, 0, 416);
      run_frame(pl, pl, 4);
    end

    // Random paddle positions including out-of-range values that must clamp.
    for (int f = 0; f < 300; f++)
      run_frame(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 4);

    // Paddles dodge the ball so points are scored until the game ends.
    for (int f = 0; f < 3000 && !(m_sl == 9 || m_sr == 9); f++) begin
      pl = (m_y < 200) ? 416 : 0;
      run_frame(pl, pl, 2);
    end
    check("game_over_reached", int'(bus.score_l == 4'd9 || bus.score_r == 4'd9), 1);

    // Game over: ball frozen at centre, scores stay put.
    for (int f = 0; f < 70; f++)
      run_frame(100, 300, 2);
    check("frozen_x", int'(dut.ball_x), 316);
    check("frozen_y", int'(dut.ball_y), 236);
    drive_px(319, 5, 1'b1);
    step();
    check("net_y5", int'(bus.vga_RGB), NETFG);
    drive_px(319, 16, 1'b1);
    step();
    check("net_y16", int'(bus.vga_RGB), 0);
    drive_px(0, 0, 1'b0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
